// File: rtl/jlsemi_util_clkgate_ctrl_if.sv
// ---------------------------------------------------------------------------
// jlsemi_util_clkgate_ctrl_if
// Groups the request/status signals between a gated functional domain (plus
// its software/DFT control) and the clock-gate controller.
//
// Handshake semantics: there is no valid/ready pair. wake_req_i, busy_i and
// force_on_i are levels sampled on every clock edge. clk_rdy_o and clk_off_o
// are registered status levels: clk_rdy_o=1 means the gated clock is running,
// clk_off_o=1 means it is stopped, and both 0 means a transition is in flight.
//
// Signals:
//   wake_req_i      level request to keep/turn the gated clock on
//   busy_i          activity from the gated domain (same effect as wake_req_i)
//   force_on_i      override: never auto-gate while high
//   idle_thr_i      consecutive idle cycles before gating (0 = never gate)
//   clk_en_o        registered enable to the clock-gate cell
//   clk_rdy_o       gated clock guaranteed running
//   clk_off_o       gated clock guaranteed stopped
//   wake_cnt_o      saturating count of OFF->WAKE transitions
//   dbg_state_o     current controller state (OFF=0, WAKE=1, ON=2, DRAIN=3)
//   dbg_idle_cnt_o  current idle counter value
// Modports:
//   master  the side that issues requests and observes status
//   slave   the controller
// ---------------------------------------------------------------------------
interface jlsemi_util_clkgate_ctrl_if #(
    parameter int IDLE_W = 8,
    parameter int WCNT_W = 16
);
    logic              wake_req_i;
    logic              busy_i;
    logic              force_on_i;
    logic [IDLE_W-1:0] idle_thr_i;
    logic              clk_en_o;
    logic              clk_rdy_o;
    logic              clk_off_o;
    logic [WCNT_W-1:0] wake_cnt_o;
    logic [1:0]        dbg_state_o;
    logic [IDLE_W-1:0] dbg_idle_cnt_o;

    modport master (
        output wake_req_i, busy_i, force_on_i, idle_thr_i,
        input  clk_en_o, clk_rdy_o, clk_off_o, wake_cnt_o,
        input  dbg_state_o, dbg_idle_cnt_o
    );

    modport slave (
        input  wake_req_i, busy_i, force_on_i, idle_thr_i,
        output clk_en_o, clk_rdy_o, clk_off_o, wake_cnt_o,
        output dbg_state_o, dbg_idle_cnt_o
    );
endinterface

// File: rtl/jlsemi_util_clkgate_ctrl.sv
// ---------------------------------------------------------------------------
// jlsemi_util_clkgate_ctrl
// Drives clk_en for a downstream synchronising clock-gate cell. Wakes the
// gated domain on request/activity, reports clock-ready only after the gate's
// enable latency, auto-gates after a programmable idle period and reports
// clock-off only after the gate-off latency. All outputs are registered.
//
// Parameters:
//   EN_LAT  cycles from a clk_en_o edge to the gate output changing (>=1)
//   IDLE_W  width of the idle threshold and idle counter
//   WCNT_W  width of the saturating wake-event counter
// Ports:
//   clk_i   always-on clock (same clock as the gate cell)
//   rst_i   asynchronous reset, active high
//   bus     slave side of jlsemi_util_clkgate_ctrl_if (requests in, status out)
// ---------------------------------------------------------------------------
module jlsemi_util_clkgate_ctrl #(
    parameter int EN_LAT = 4,
    parameter int IDLE_W = 8,
    parameter int WCNT_W = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    jlsemi_util_clkgate_ctrl_if.slave   bus
);
    // lat_cnt counts up to EN_LAT (it also increments on the exit edge).
    localparam int LAT_W = $clog2(EN_LAT + 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(EN_LAT - 1);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_WAKE  = 2'd1,
        ST_ON    = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t            state_q,    state_d;
    logic [LAT_W-1:0]  lat_cnt_q,  lat_cnt_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic              clk_en_q,   clk_en_d;
    logic              clk_rdy_q,  clk_rdy_d;
    logic              clk_off_q,  clk_off_d;
    logic [WCNT_W-1:0] wake_cnt_q, wake_cnt_d;

    logic              act;
    logic [IDLE_W:0]   idle_next;

    always_comb begin
        state_d    = state_q;
        lat_cnt_d  = lat_cnt_q;
        idle_cnt_d = idle_cnt_q;
        clk_en_d   = clk_en_q;
        clk_rdy_d  = clk_rdy_q;
        clk_off_d  = clk_off_q;
        wake_cnt_d = wake_cnt_q;

        act = bus.wake_req_i | bus.busy_i | bus.force_on_i;
        // One bit wider so the threshold compare cannot wrap at all-ones.
        idle_next = {1'b0, idle_cnt_q} + (IDLE_W + 1)'(1);

        case (state_q)
            ST_OFF: begin
                if (act) begin
                    state_d   = ST_WAKE;
                    clk_en_d  = 1'b1;
                    clk_off_d = 1'b0;
                    lat_cnt_d = '0;
                    if (wake_cnt_q != '1) begin
                        wake_cnt_d = wake_cnt_q + WCNT_W'(1);
                    end
                end
            end

            ST_WAKE: begin
                // Wake is committed once started; act is ignored here.
                lat_cnt_d = lat_cnt_q + LAT_W'(1);
                if (lat_cnt_q == LAT_LAST) begin
                    state_d    = ST_ON;
                    clk_rdy_d  = 1'b1;
                    idle_cnt_d = '0;
                end
            end

            ST_ON: begin
                if (act) begin
                    idle_cnt_d = '0;
                end else if (bus.idle_thr_i != '0) begin
                    if (idle_cnt_q != '1) begin
                        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                    end
                    // Gate on the idle_thr-th idle cycle; a threshold lowered
                    // below the running count gates on the next idle cycle.
                    if (idle_next >= {1'b0, bus.idle_thr_i}) begin
                        state_d   = ST_DRAIN;
                        clk_en_d  = 1'b0;
                        clk_rdy_d = 1'b0;
                        lat_cnt_d = '0;
                    end
                end
            end

            ST_DRAIN: begin
                // Drain always completes; a new request re-wakes from OFF.
                lat_cnt_d = lat_cnt_q + LAT_W'(1);
                if (lat_cnt_q == LAT_LAST) begin
                    state_d   = ST_OFF;
                    clk_off_d = 1'b1;
                end
            end

            default: begin
                state_d   = ST_OFF;
                clk_en_d  = 1'b0;
                clk_rdy_d = 1'b0;
                clk_off_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_OFF;
            lat_cnt_q  <= '0;
            idle_cnt_q <= '0;
            clk_en_q   <= 1'b0;
            clk_rdy_q  <= 1'b0;
            clk_off_q  <= 1'b1;
            wake_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lat_cnt_q  <= lat_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            clk_en_q   <= clk_en_d;
            clk_rdy_q  <= clk_rdy_d;
            clk_off_q  <= clk_off_d;
            wake_cnt_q <= wake_cnt_d;
        end
    end

    assign bus.clk_en_o       = clk_en_q;
    assign bus.clk_rdy_o      = clk_rdy_q;
    assign bus.clk_off_o      = clk_off_q;
    assign bus.wake_cnt_o     = wake_cnt_q;
    assign bus.dbg_state_o    = state_q;
    assign bus.dbg_idle_cnt_o = idle_cnt_q;

endmodule

// File: tb/tb_jlsemi_util_clkgate_ctrl.sv
// ---------------------------------------------------------------------------
// tb_jlsemi_util_clkgate_ctrl
// Bench for the clock-gate controller. Instance a: EN_LAT=4, WCNT_W=16.
// Instance b: EN_LAT=4, WCNT_W=2 for wake-counter saturation.
// Expected output changes of instance a are queued as {cycle, en, rdy, off,
// wake_cnt}; a monitor pops one entry whenever the outputs change.
// ---------------------------------------------------------------------------
module tb_jlsemi_util_clkgate_ctrl;
    localparam int W = 32 + 3 + 16;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cyc = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    jlsemi_util_clkgate_ctrl_if #(.IDLE_W(8), .WCNT_W(16)) bus_a ();
    jlsemi_util_clkgate_ctrl_if #(.IDLE_W(8), .WCNT_W(2))  bus_b ();

    jlsemi_util_clkgate_ctrl #(.EN_LAT(4), .IDLE_W(8), .WCNT_W(16)) dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_a)
    );

    jlsemi_util_clkgate_ctrl #(.EN_LAT(4), .IDLE_W(8), .WCNT_W(2)) dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_b)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           checks = 0;
    int           errors = 0;
    logic         mon_en = 1'b0;
    logic [18:0]  prev_obs;
    logic         t3_en = 1'b0;
    logic [7:0]   idle_max = '0;

    function automatic void push(logic [31:0] c, logic en, logic rdy, logic off, logic [15:0] wc);
        exp_q.push_back({c, en, rdy, off, wc});
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: pops an expectation on every change of instance a's outputs.
    always @(negedge clk) begin
        logic [18:0]  obs;
        logic [W-1:0] e;
        if (mon_en) begin
            obs = {bus_a.clk_en_o, bus_a.clk_rdy_o, bus_a.clk_off_o, bus_a.wake_cnt_o};
            checks++;
            if ((obs[18:16] == 3'b111) || (obs[17] && !obs[18]) ||
                (obs[16] && obs[18]) || (obs[17] && obs[16])) begin
                errors++;
                $display("FAIL invariant en/rdy/off=%b cyc %0d", obs[18:16], cyc);
            end
            if (obs !== prev_obs) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change got cyc %0d en/rdy/off=%b wc=%0d",
                             cyc, obs[18:16], obs[15:0]);
                end else begin
                    e = exp_q.pop_front();
                    if (e !== {cyc, obs}) begin
                        errors++;
                        $display("FAIL sb_event got cyc %0d en/rdy/off=%b wc=%0d exp cyc %0d en/rdy/off=%b wc=%0d",
                                 cyc, obs[18:16], obs[15:0], e[W-1:19], e[18:16], e[15:0]);
                    end
                end
                prev_obs = obs;
            end
        end
    end

    always @(negedge clk) begin
        if (t3_en && (bus_a.dbg_idle_cnt_o > idle_max)) idle_max = bus_a.dbg_idle_cnt_o;
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] b;
        bus_a.wake_req_i = 1'b0;
        bus_a.busy_i     = 1'b0;
        bus_a.force_on_i = 1'b0;
        bus_a.idle_thr_i = 8'd8;
        bus_b.wake_req_i = 1'b0;
        bus_b.busy_i     = 1'b0;
        bus_b.force_on_i = 1'b0;
        bus_b.idle_thr_i = 8'd1;

        tick(3);
        chk("rst_en",    32'(bus_a.clk_en_o), 32'd0);
        chk("rst_rdy",   32'(bus_a.clk_rdy_o), 32'd0);
        chk("rst_off",   32'(bus_a.clk_off_o), 32'd1);
        chk("rst_wcnt",  32'(bus_a.wake_cnt_o), 32'd0);
        chk("rst_state", 32'(bus_a.dbg_state_o), 32'd0);
        prev_obs = {3'b001, 16'd0};
        mon_en   = 1'b1;

        // 1: reset release with wake_req held.
        bus_a.wake_req_i = 1'b1;
        tick(1);
        rst = 1'b0;
        b = cyc;
        push(b + 1, 1, 0, 0, 16'd1);
        push(b + 5, 1, 1, 0, 16'd1);
        tick(6);
        chk("t1_state_on", 32'(bus_a.dbg_state_o), 32'd2);

        // 2: all activity drops; gate after 8 idle edges, off 4 later.
        bus_a.wake_req_i = 1'b0;
        b = cyc;
        push(b + 8,  0, 0, 0, 16'd1);
        push(b + 12, 0, 0, 1, 16'd1);
        tick(14);

        // 4: wake, go idle, re-request 2 cycles into drain.
        bus_a.wake_req_i = 1'b1;
        b = cyc;
        push(b + 1, 1, 0, 0, 16'd2);
        push(b + 5, 1, 1, 0, 16'd2);
        tick(5);
        bus_a.wake_req_i = 1'b0;
        push(b + 13, 0, 0, 0, 16'd2);
        push(b + 17, 0, 0, 1, 16'd2);
        push(b + 18, 1, 0, 0, 16'd3);
        push(b + 22, 1, 1, 0, 16'd3);
        tick(10);
        bus_a.wake_req_i = 1'b1;
        tick(8);

        // 3: busy pulses once every 7 cycles; never gates.
        bus_a.wake_req_i = 1'b0;
        t3_en = 1'b1;
        repeat (30) begin
            bus_a.busy_i = 1'b1;
            tick(1);
            bus_a.busy_i = 1'b0;
            tick(6);
        end
        t3_en = 1'b0;
        chk("t3_idle_max", 32'(idle_max), 32'd6);
        chk("t3_en", 32'(bus_a.clk_en_o), 32'd1);

        // 5: threshold 0, then force_on, each 500 idle cycles.
        bus_a.idle_thr_i = 8'd0;
        tick(500);
        chk("t5_thr0_rdy", 32'(bus_a.clk_rdy_o), 32'd1);
        bus_a.idle_thr_i = 8'd8;
        bus_a.force_on_i = 1'b1;
        tick(500);
        chk("t5_force_rdy", 32'(bus_a.clk_rdy_o), 32'd1);
        chk("t5_force_state", 32'(bus_a.dbg_state_o), 32'd2);
        bus_a.force_on_i = 1'b0;
        b = cyc;
        push(b + 8,  0, 0, 0, 16'd3);
        push(b + 12, 0, 0, 1, 16'd3);
        tick(13);

        // Lowering the threshold below the idle count gates on the next idle edge.
        bus_a.wake_req_i = 1'b1;
        b = cyc;
        push(b + 1, 1, 0, 0, 16'd4);
        push(b + 5, 1, 1, 0, 16'd4);
        tick(5);
        bus_a.wake_req_i = 1'b0;
        tick(5);
        chk("thr_low_idle", 32'(bus_a.dbg_idle_cnt_o), 32'd5);
        bus_a.idle_thr_i = 8'd3;
        push(b + 11, 0, 0, 0, 16'd4);
        push(b + 15, 0, 0, 1, 16'd4);
        tick(16);
        bus_a.idle_thr_i = 8'd8;

        // 6: reset mid-WAKE with lat_cnt=2.
        bus_a.wake_req_i = 1'b1;
        b = cyc;
        push(b + 1, 1, 0, 0, 16'd5);
        push(b + 3, 0, 0, 1, 16'd0);
        tick(3);
        chk("t6_pre_state", 32'(bus_a.dbg_state_o), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_en",    32'(bus_a.clk_en_o), 32'd0);
        chk("t6_rdy",   32'(bus_a.clk_rdy_o), 32'd0);
        chk("t6_off",   32'(bus_a.clk_off_o), 32'd1);
        chk("t6_wcnt",  32'(bus_a.wake_cnt_o), 32'd0);
        bus_a.wake_req_i = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(20);
        chk("t6_stay_off", 32'(bus_a.dbg_state_o), 32'd0);

        // Saturation of a 2-bit wake counter over 5 wakes.
        for (int i = 1; i <= 5; i++) begin
            bus_b.wake_req_i = 1'b1;
            tick(1);
            bus_b.wake_req_i = 1'b0;
            tick(12);
            chk($sformatf("sat_wcnt_%0d", i), 32'(bus_b.wake_cnt_o), (i < 3) ? i : 3);
        end
        chk("sat_off", 32'(bus_b.clk_off_o), 32'd1);

        tick(2);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
